// File: rtl/demux_1to8_tdm_pkg.sv
// Shared types and sizing for the 1-to-8 TDM serial demultiplexer.
package demux_1to8_tdm_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/demux_slot_ctr.sv
// Slot index counter: clear, load-to-1 on sync, and modulo-8 increment.
module demux_slot_ctr
    import demux_1to8_tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_load1,
    input  logic              i_inc,
    output logic [SLOT_W-1:0] o_slot
);

    logic [SLOT_W-1:0] r_slot;

    // Clear beats load, load beats increment; the 3-bit add wraps 7 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else if (i_clr) begin
            r_slot <= '0;
        end else if (i_load1) begin
            r_slot <= SLOT_W'(1);
        end else if (i_inc) begin
            r_slot <= r_slot + 1'b1;
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/demux_1to8_tdm.sv
// Serial TDM demultiplexer: frames 8 sync-aligned bits into a registered byte.
module demux_1to8_tdm
    import demux_1to8_tdm_pkg::*;
#(
    parameter bit STRICT_SYNC = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_vld,
    input  logic              sync,
    output logic [7:0]        y,
    output logic              frame_vld,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_SLOTS-2:0]   r_shadow;
    logic [NUM_SLOTS-2:0]   w_shadow_nxt;
    logic [7:0]             r_y;
    logic [7:0]             w_y_nxt;
    logic                   r_frame_vld;
    logic                   r_sync_err;
    logic                   r_locked;
    logic                   w_frame;
    logic                   w_err;
    logic                   w_clr;
    logic                   w_load1;
    logic                   w_inc;
    logic [SLOT_W-1:0]      w_slot;

    demux_slot_ctr u_slot_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_load1 (w_load1),
        .i_inc   (w_inc),
        .o_slot  (w_slot)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_y_nxt      = r_y;
        w_frame      = 1'b0;
        w_err        = 1'b0;
        w_clr        = 1'b0;
        w_load1      = 1'b0;
        w_inc        = 1'b0;
        if (din_vld) begin
            case (r_state)
                HUNT: begin
                    if (sync) begin
                        w_shadow_nxt[0] = din;
                        w_load1         = 1'b1;
                        w_state_nxt     = LOCKED;
                    end
                end
                LOCKED: begin
                    // Early sync (including at slot 7) restarts the frame instead of completing it.
                    if (sync && (w_slot != '0)) begin
                        w_err           = 1'b1;
                        w_shadow_nxt[0] = din;
                        w_load1         = 1'b1;
                    end else if (STRICT_SYNC && !sync && (w_slot == '0)) begin
                        w_err       = 1'b1;
                        w_clr       = 1'b1;
                        w_state_nxt = HUNT;
                    end else if (w_slot == LAST_SLOT) begin
                        w_y_nxt = {din, r_shadow};
                        w_frame = 1'b1;
                        w_inc   = 1'b1;
                    end else begin
                        w_shadow_nxt[w_slot] = din;
                        w_inc                = 1'b1;
                    end
                end
                default: begin
                    w_clr       = 1'b1;
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HUNT;
            r_shadow    <= '0;
            r_y         <= 8'h00;
            r_frame_vld <= 1'b0;
            r_sync_err  <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shadow    <= w_shadow_nxt;
            r_y         <= w_y_nxt;
            r_frame_vld <= w_frame;
            r_sync_err  <= w_err;
            r_locked    <= (w_state_nxt == LOCKED);
        end
    end

    assign y         = r_y;
    assign frame_vld = r_frame_vld;
    assign slot      = w_slot;
    assign locked    = r_locked;
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_demux_1to8_tdm.sv
// Bench for demux_1to8_tdm: vector table, directed corner sequences, and random traffic vs a model.
module tb_demux_1to8_tdm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_vld = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] y0, y1;
    logic       fv0, fv1, lk0, lk1, er0, er1;
    logic [2:0] sl0, sl1;

    demux_1to8_tdm #(.STRICT_SYNC(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .sync(sync),
        .y(y0), .frame_vld(fv0), .slot(sl0), .locked(lk0), .sync_err(er0));

    demux_1to8_tdm #(.STRICT_SYNC(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .sync(sync),
        .y(y1), .frame_vld(fv1), .slot(sl1), .locked(lk1), .sync_err(er1));

    always #5 clk = ~clk;

    typedef struct {
        bit       lk;
        int       slot;
        bit [7:0] sh;
        bit [7:0] y;
        bit       fv;
        bit       er;
    } mdl_t;

    typedef struct {
        bit         v;
        bit         s;
        bit         d;
        logic [7:0] y;
        bit         fv;
        logic [2:0] slot;
        bit         lk;
        bit         er;
    } vec_t;

    mdl_t m0, m1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc_n = 0;

    // Frame-level behaviour: bits collect by slot; a full 8-slot run publishes the byte.
    function automatic mdl_t mstep(input mdl_t mi, input bit strict, input bit v, input bit s, input bit d);
        mdl_t m = mi;
        m.fv = 1'b0;
        m.er = 1'b0;
        if (v) begin
            if (!m.lk) begin
                if (s) begin
                    m.sh[0] = d;
                    m.slot  = 1;
                    m.lk    = 1'b1;
                end
            end else if (s && m.slot != 0) begin
                m.er    = 1'b1;
                m.sh[0] = d;
                m.slot  = 1;
            end else if (!s && m.slot == 0 && strict) begin
                m.er   = 1'b1;
                m.lk   = 1'b0;
                m.slot = 0;
            end else begin
                m.sh[m.slot] = d;
                if (m.slot == 7) begin
                    m.y  = m.sh;
                    m.fv = 1'b1;
                end
                m.slot = (m.slot + 1) % 8;
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] mpack(input mdl_t m);
        return 32'({m.y, m.fv, 3'(m.slot), m.lk, m.er});
    endfunction

    task automatic mreset();
        m0.lk = 0; m0.slot = 0; m0.sh = 0; m0.y = 0; m0.fv = 0; m0.er = 0;
        m1 = m0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    task automatic check_both_vs_model();
        check("ref_loose",  32'({y0, fv0, sl0, lk0, er0}), mpack(m0));
        check("ref_strict", 32'({y1, fv1, sl1, lk1, er1}), mpack(m1));
    endtask

    task automatic beat(input bit v, input bit s, input bit d);
        din_vld = v;
        sync    = s;
        din     = d;
        @(posedge clk);
        m0 = mstep(m0, 1'b0, v, s, d);
        m1 = mstep(m1, 1'b1, v, s, d);
        cyc_n++;
        #1;
        check_both_vs_model();
        din_vld = 1'b0;
        sync    = 1'b0;
        din     = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        mreset();
        check("async_rst_y",      32'(y0), 32'h00);
        check("async_rst_locked", 32'(lk0), 32'h0);
        check_both_vs_model();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] f, output int fv_seen, output logic [7:0] y_at_fv);
        fv_seen = 0;
        y_at_fv = 8'h00;
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, i == 0, f[i]);
            if (fv0) begin
                fv_seen++;
                y_at_fv = y0;
            end
        end
    endtask

    initial begin
        vec_t       tbl[8];
        logic [7:0] pat;
        logic [7:0] fy;
        int         fcyc, errs, nfv;
        int         fv_cyc[$];

        pat = 8'h4D;
        for (int i = 0; i < 8; i++) begin
            tbl[i].v    = 1'b1;
            tbl[i].s    = (i == 0);
            tbl[i].d    = pat[i];
            tbl[i].y    = (i == 7) ? 8'h4D : 8'h00;
            tbl[i].fv   = (i == 7);
            tbl[i].slot = 3'((i + 1) % 8);
            tbl[i].lk   = 1'b1;
            tbl[i].er   = 1'b0;
        end

        mreset();
        #2;
        check("reset_state", 32'({y0, fv0, sl0, lk0, er0}), 32'h0);
        check_both_vs_model();
        rst_n = 1'b1;

        // Basic frame from the vector table.
        for (int i = 0; i < 8; i++) begin
            beat(tbl[i].v, tbl[i].s, tbl[i].d);
            check("tbl_vec", 32'({y0, fv0, sl0, lk0, er0}),
                  32'({tbl[i].y, tbl[i].fv, tbl[i].slot, tbl[i].lk, tbl[i].er}));
        end

        // Same frame with a 3-cycle gap after slot 3.
        fcyc = -1;
        errs = 0;
        for (int i = 0; i < 11; i++) begin
            bit v;
            int bi;
            v  = !(i >= 4 && i < 7);
            bi = (i < 4) ? i : i - 3;
            beat(v, v && (bi == 0), v ? pat[bi] : 1'b0);
            if (fv0) fcyc = i;
            errs += int'(er0);
        end
        check("gap_fv_cycle", 32'(fcyc), 32'd10);
        check("gap_no_err",   32'(errs), 32'd0);
        check("gap_y",        32'(y0), 32'h4D);

        // Early sync at slot 5 resyncs; following 7 zero bits give 8'h01.
        for (int i = 0; i < 5; i++) beat(1'b1, i == 0, 1'b1);
        beat(1'b1, 1'b1, 1'b1);
        check("early_err",  32'(er0), 32'h1);
        check("early_slot", 32'(sl0), 32'd1);
        check("early_y",    32'(y0), 32'h4D);
        nfv = 0;
        for (int i = 0; i < 7; i++) begin
            beat(1'b1, 1'b0, 1'b0);
            nfv += int'(fv0);
        end
        check("resync_y",  32'(y0), 32'h01);
        check("resync_fv", 32'(nfv), 32'd1);

        // Early sync at slot 7: resync, not a frame completion.
        for (int i = 0; i < 7; i++) beat(1'b1, i == 0, 1'b1);
        beat(1'b1, 1'b1, 1'b0);
        check("slot7_sync", 32'({fv0, er0, sl0}), 32'({1'b0, 1'b1, 3'd1}));
        check("slot7_y",    32'(y0), 32'h01);
        for (int i = 0; i < 7; i++) beat(1'b1, 1'b0, 1'b0);

        // Strict instance: second frame without sync drops to HUNT.
        send_frame(8'hA5, nfv, fy);
        beat(1'b1, 1'b0, 1'b0);
        check("strict_err",  32'({er1, lk1, sl1}), 32'({1'b1, 1'b0, 3'd0}));
        check("strict_y",    32'(y1), 32'hA5);
        for (int i = 1; i < 8; i++) beat(1'b1, 1'b0, 1'b1);
        check("strict_hold", 32'({y1, lk1, sl1}), 32'({8'hA5, 1'b0, 3'd0}));

        // Async reset at slot 4, then unsynced beats are ignored.
        for (int i = 0; i < 4; i++) beat(1'b1, i == 0, 1'b1);
        check("pre_rst_slot", 32'(sl0), 32'd4);
        async_reset();
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'b1);
        check("post_rst_hunt", 32'({y0, lk0, sl0}), 32'h0);

        // Three back-to-back frames.
        errs = 0;
        for (int f = 0; f < 3; f++) begin
            logic [7:0] fr;
            fr = (f == 0) ? 8'hA5 : (f == 1) ? 8'h3C : 8'hFF;
            for (int i = 0; i < 8; i++) begin
                beat(1'b1, i == 0, fr[i]);
                if (fv0) begin
                    fv_cyc.push_back(cyc_n);
                    check("b2b_y", 32'(y0), 32'(fr));
                end
                errs += int'(er0);
            end
        end
        check("b2b_count", 32'(fv_cyc.size()), 32'd3);
        if (fv_cyc.size() == 3) begin
            check("b2b_gap1", 32'(fv_cyc[1] - fv_cyc[0]), 32'd8);
            check("b2b_gap2", 32'(fv_cyc[2] - fv_cyc[1]), 32'd8);
        end
        check("b2b_no_err", 32'(errs), 32'd0);

        // Randomized traffic, mostly well framed with occasional violations and resets.
        for (int i = 0; i < 3000; i++) begin
            bit v, s, d;
            v = ($urandom_range(0, 3) != 0);
            if (m0.slot == 0) s = ($urandom_range(0, 7) != 0);
            else              s = ($urandom_range(0, 15) == 0);
            d = 1'($urandom_range(0, 1));
            beat(v, s, d);
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
